// File: rtl/cordic_iter_stage.sv
// cordic_iter_stage: one rotation-mode CORDIC micro-rotation with 2-entry skid.
// Optional round-half-up of the shifted terms: define CORDIC_ROUND_EN.
module cordic_iter_stage #(
  parameter int                             WORD_LENGTH = 21,
  parameter int                             SHIFT       = 0,
  parameter logic signed [WORD_LENGTH-1:0]  ATAN_ANGLE  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] x_i,
  input  logic [WORD_LENGTH-1:0] y_i,
  input  logic [WORD_LENGTH-1:0] z_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] x_o,
  output logic [WORD_LENGTH-1:0] y_o,
  output logic [WORD_LENGTH-1:0] z_o
);

  localparam int W = WORD_LENGTH;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } beat_t;

  logic signed [W-1:0] xin;
  logic signed [W-1:0] yin;
  logic signed [W-1:0] xs;
  logic signed [W-1:0] ys;
  logic                dneg;
  beat_t               nxt;

  assign xin  = $signed(x_i);
  assign yin  = $signed(y_i);
  assign dneg = z_i[W-1];

`ifdef CORDIC_ROUND_EN
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [W:0] HALF =
        (W+1)'(1) <<< (SHIFT - 1);
      logic signed [W:0] xr;
      logic signed [W:0] yr;
      assign xr = {xin[W-1], xin} + HALF;
      assign yr = {yin[W-1], yin} + HALF;
      assign xs = W'(xr >>> SHIFT);
      assign ys = W'(yr >>> SHIFT);
    end else begin : g_noround
      assign xs = xin;
      assign ys = yin;
    end
  endgenerate
`else
  assign xs = xin >>> SHIFT;
  assign ys = yin >>> SHIFT;
`endif

  always_comb begin
    nxt   = '0;
    nxt.x = dneg ? x_i + ys : x_i - ys;
    nxt.y = dneg ? y_i - xs : y_i + xs;
    nxt.z = dneg ? z_i + ATAN_ANGLE : z_i - ATAN_ANGLE;
  end

  beat_t out_q, out_n;
  beat_t sk_q, sk_n;
  logic  ov_q, ov_n;
  logic  sv_q, sv_n;
  logic  rdy_q;
  logic  acc;
  logic  free;

  assign acc  = in_valid && rdy_q;
  assign free = !ov_q || out_ready;

  // skid only ever fills while the output is stalled, so it drains first
  always_comb begin
    out_n = out_q;
    ov_n  = ov_q;
    sk_n  = sk_q;
    sv_n  = sv_q;
    unique case (1'b1)
      free && sv_q: begin
        out_n = sk_q;
        ov_n  = 1'b1;
        sv_n  = 1'b0;
      end
      free && !sv_q && acc: begin
        out_n = nxt;
        ov_n  = 1'b1;
      end
      free && !sv_q && !acc: begin
        ov_n = 1'b0;
      end
      !free && acc: begin
        sk_n = nxt;
        sv_n = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      sk_q  <= '0;
      ov_q  <= 1'b0;
      sv_q  <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      out_q <= out_n;
      sk_q  <= sk_n;
      ov_q  <= ov_n;
      sv_q  <= sv_n;
      rdy_q <= !sv_n;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = ov_q;
  assign x_o       = out_q.x;
  assign y_o       = out_q.y;
  assign z_o       = out_q.z;

endmodule

// File: tb/tb_cordic_iter_stage.sv
// tb_cordic_iter_stage: directed and randomized checks of two stage configs
// against an arithmetic reference model with a FIFO scoreboard.
module tb_cordic_iter_stage;

  localparam int WL = 21;

  typedef struct {
    longint x;
    longint y;
    longint z;
  } bt;

  logic          clk = 1'b0;
  logic          rst;
  logic          iv[2];
  logic          ir[2];
  logic          ov[2];
  logic          ordy[2];
  logic [WL-1:0] xi[2];
  logic [WL-1:0] yi[2];
  logic [WL-1:0] zi[2];
  logic [WL-1:0] xo[2];
  logic [WL-1:0] yo[2];
  logic [WL-1:0] zo[2];

  int     checks = 0;
  int     errors = 0;
  int     sh[2]  = '{0, 2};
  longint at[2]  = '{12868, 1000};
  bt      sb[2][$];
  bt      e;
  bt      ea;
  bt      eb;
  bt      ec;
  logic   pend[2];

  always #5 clk = ~clk;

  cordic_iter_stage #(
    .WORD_LENGTH(WL), .SHIFT(0), .ATAN_ANGLE(21'sd12868)
  ) u0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .x_i(xi[0]), .y_i(yi[0]), .z_i(zi[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .x_o(xo[0]), .y_o(yo[0]), .z_o(zo[0])
  );

  cordic_iter_stage #(
    .WORD_LENGTH(WL), .SHIFT(2), .ATAN_ANGLE(21'sd1000)
  ) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .x_i(xi[1]), .y_i(yi[1]), .z_i(zi[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .x_o(xo[1]), .y_o(yo[1]), .z_o(zo[1])
  );

  function automatic longint wrapw(longint v);
    longint m;
    m = v & ((64'sd1 <<< WL) - 1);
    if (m >= (64'sd1 <<< (WL - 1))) m = m - (64'sd1 <<< WL);
    return m;
  endfunction

  function automatic longint fdiv(longint a, longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint shv(longint v, int s);
`ifdef CORDIC_ROUND_EN
    if (s > 0) return fdiv(v + (64'sd1 <<< (s - 1)), 64'sd1 <<< s);
`endif
    return fdiv(v, 64'sd1 <<< s);
  endfunction

  function automatic bt model(int k, longint x, longint y, longint z);
    bt r;
    longint d;
    d   = (z < 0) ? -1 : 1;
    r.x = wrapw(x - d * shv(y, sh[k]));
    r.y = wrapw(y + d * shv(x, sh[k]));
    r.z = wrapw(z - d * at[k]);
    return r;
  endfunction

  function automatic longint sx(logic [WL-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(int k, longint x, longint y, longint z);
    iv[k] = 1'b1;
    xi[k] = x[WL-1:0];
    yi[k] = y[WL-1:0];
    zi[k] = z[WL-1:0];
  endtask

  task automatic chk_out(string tag, int k, bt ex);
    chk({tag, "_v"}, longint'(ov[k]), 1);
    chk({tag, "_x"}, sx(xo[k]), ex.x);
    chk({tag, "_y"}, sx(yo[k]), ex.y);
    chk({tag, "_z"}, sx(zo[k]), ex.z);
  endtask

  task automatic one_beat(string tag, int k, longint x, longint y,
                          longint z, bt ex);
    @(negedge clk);
    ordy[k] = 1'b1;
    drive(k, x, y, z);
    @(negedge clk);
    iv[k] = 1'b0;
    chk_out(tag, k, ex);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; pend[k] = 1'b0;
      xi[k] = '0; yi[k] = '0; zi[k] = '0;
    end
    #12 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ov", longint'(ov[k]), 0);
      chk("rst_ir", longint'(ir[k]), 1);
      chk("rst_x", sx(xo[k]), 0);
      chk("rst_z", sx(zo[k]), 0);
    end

    e = '{1000, 1000, -12768};
    one_beat("basic", 0, 1000, 0, 100, e);
    e = '{1100, 150, 995};
    one_beat("negdir", 1, 1000, 400, -5, e);
`ifdef CORDIC_ROUND_EN
    e = '{998, 256, -1000};
`else
    e = '{999, 256, -1000};
`endif
    one_beat("round", 1, 1000, 6, 0, e);
    e = '{-1048576, 1048574, -12868};
    one_beat("wrap", 0, 1048575, -1, 0, e);
    @(negedge clk);
    chk("drain_ov", longint'(ov[0]), 0);

    // back-pressure: A on output, B in skid, C held off
    ea = model(1, 300, -700, 40);
    eb = model(1, -5000, 123, -9);
    ec = model(1, 77, 88, 99);
    ordy[1] = 1'b0;
    drive(1, 300, -700, 40);
    @(negedge clk);
    chk_out("bp_a", 1, ea);
    chk("bp_ir1", longint'(ir[1]), 1);
    drive(1, -5000, 123, -9);
    @(negedge clk);
    chk("bp_ir0", longint'(ir[1]), 0);
    chk_out("bp_hold", 1, ea);
    drive(1, 77, 88, 99);
    @(negedge clk);
    chk("bp_ir0b", longint'(ir[1]), 0);
    chk_out("bp_hold2", 1, ea);
    ordy[1] = 1'b1;
    @(negedge clk);
    chk_out("bp_b", 1, eb);
    chk("bp_ir1b", longint'(ir[1]), 1);
    @(negedge clk);
    iv[1] = 1'b0;
    chk_out("bp_c", 1, ec);
    @(negedge clk);
    chk("bp_empty", longint'(ov[1]), 0);

    // reset while A on output and B in skid
    ordy[1] = 1'b0;
    drive(1, 1, 2, 3);
    @(negedge clk);
    drive(1, 4, 5, 6);
    @(negedge clk);
    iv[1] = 1'b0;
    chk("rs_ir0", longint'(ir[1]), 0);
    #2 rst = 1'b1;
    #1;
    chk("rs_ov", longint'(ov[1]), 0);
    chk("rs_x", sx(xo[1]), 0);
    chk("rs_y", sx(yo[1]), 0);
    chk("rs_z", sx(zo[1]), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rs_ir1", longint'(ir[1]), 1);
    ordy[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rs_gone", longint'(ov[1]), 0);
    end

    // randomized traffic against FIFO scoreboard
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("r_ov", longint'(ov[k]), longint'(sb[k].size() > 0));
        chk("r_ir", longint'(ir[k]), longint'(sb[k].size() < 2));
        if (ov[k] && sb[k].size() > 0) begin
          chk("r_x", sx(xo[k]), sb[k][0].x);
          chk("r_y", sx(yo[k]), sb[k][0].y);
          chk("r_z", sx(zo[k]), sb[k][0].z);
        end
        ordy[k] = ($urandom_range(0, 9) < 6);
        if (!pend[k]) begin
          iv[k] = ($urandom_range(0, 9) < 7);
          xi[k] = WL'($urandom);
          yi[k] = WL'($urandom);
          zi[k] = WL'($urandom);
        end
        if (ov[k] && ordy[k] && sb[k].size() > 0) void'(sb[k].pop_front());
        if (iv[k] && ir[k])
          sb[k].push_back(model(k, sx(xi[k]), sx(yi[k]), sx(zi[k])));
        pend[k] = iv[k] && !ir[k];
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cordic_iter_stage.md
Name: cordic_iter_stage

Overview:
One CORDIC micro-rotation, rotation mode, for the unfolded CORDIC pipeline. Each iteration slot uses one instance, configured with its shift index and arctangent constant. The stage computes the next x/y/z from the current values and registers the result behind a valid/ready handshake. A 2-entry skid buffer lets back-pressure propagate stage by stage with no combinational ready path, and the stage is chained directly into the next stage.

Parameters:
WORD_LENGTH, 21, width of x, y and z in two's complement.
SHIFT, 0, iteration index i; x and y are arithmetically right-shifted by i. Legal range is 0..WORD_LENGTH-1.
ATAN_ANGLE, 0, signed WORD_LENGTH-bit constant atan(2^-i) in the pipeline's angle units.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  upstream beat present
in_ready  output  1  stage can accept a beat; registered
x_i  input  WORD_LENGTH  current x, signed
y_i  input  WORD_LENGTH  current y, signed
z_i  input  WORD_LENGTH  current residual angle, signed
out_valid  output  1  x_o/y_o/z_o hold a valid beat
out_ready  input  1  downstream accepts the beat
x_o  output  WORD_LENGTH  next x, signed, registered
y_o  output  WORD_LENGTH  next y, signed, registered
z_o  output  WORD_LENGTH  next z, signed, registered

Behaviour:
- Reset (async, rst=1):
  - out_valid=0; x_o, y_o, z_o = 0.
  - Skid entry cleared, so in_ready=1 once rst deasserts.
  - Any beat in flight when rst asserts is discarded.
- Direction: d=+1 when z_i[MSB]=0 (z_i>=0); d=-1 otherwise.
- Arithmetic, all modulo 2^WORD_LENGTH (wrap, no saturation):
  - xs = x_i>>>SHIFT, ys = y_i>>>SHIFT.
  - x' = x_i - d*ys.
  - y' = y_i + d*xs.
  - z' = z_i - d*ATAN_ANGLE.
- Accept: a beat is taken on a rising edge when in_valid && in_ready.
- Output register (out_valid, x_o, y_o, z_o):
  - Free when out_valid=0 or out_ready=1.
  - When free, it loads the skid entry if one is held, otherwise the newly accepted beat's x'/y'/z'.
  - If neither exists, out_valid goes to 0.
- Skid entry:
  - When the output register is not free and a beat is accepted, the computed beat goes into the skid entry.
  - When the output register loads from the skid entry, the skid entry clears.
- in_ready = not skid_valid, registered.
- Latency: 1 cycle from accept to out_valid with no stall. Sustains 1 beat/cycle with out_ready held high.
- Ordering: beats always leave in accept order; no beat is dropped or duplicated.
- Stall hold: while out_valid=1 and out_ready=0, x_o, y_o, z_o stay stable.
- Simultaneous events: output draining while a new beat is accepted and the skid is empty means the new beat goes straight to the output register.
- in_valid while in_ready=0 is ignored; upstream holds its data.

Optional Feature:
CORDIC_ROUND_EN.
- Defined and SHIFT>0: xs and ys are round-half-up instead of truncated.
  - xs = (x_i + 2^(SHIFT-1))>>>SHIFT.
  - The sum is computed in WORD_LENGTH+1 bits, then truncated to WORD_LENGTH.
  - Same for ys.
- Defined and SHIFT=0: no rounding is applied.
- Not defined: plain arithmetic shift, which truncates toward -inf.
- z' and the handshake are identical in both builds.

Test Plan:
- Basic, truncating build: SHIFT=0, ATAN_ANGLE=12868, beat x=1000, y=0, z=100 with out_ready=1 -> next cycle out_valid=1, x_o=1000, y_o=1000, z_o=-12768.
- Negative direction: SHIFT=2, ATAN_ANGLE=1000, beat x=1000, y=400, z=-5 -> x_o=1100, y_o=150, z_o=995.
- Rounding: SHIFT=2, ATAN_ANGLE=1000, beat x=1000, y=6, z=0.
  - Without CORDIC_ROUND_EN -> x_o=999, y_o=256, z_o=-1000.
  - With CORDIC_ROUND_EN -> x_o=998, y_o=256, z_o=-1000.
- Wrap: SHIFT=0, beat x=1048575, y=-1, z=0 -> x_o=-1048576 (wraps), y_o=1048574.
- Back-pressure:
  - Stimulus: out_ready=0, in_valid=1 streaming beats A, B, C.
  - Required: A held on output, B in skid, in_ready=0 the cycle after B is accepted, C held off.
  - Then out_ready=1: outputs A, B, C in order on consecutive cycles, with no loss or duplicates.
- Reset mid-stall:
  - Stimulus: with A on output and B in skid, pulse rst asynchronously between clock edges.
  - Required: out_valid=0 and x_o/y_o/z_o=0 immediately; in_ready=1 after release; A and B never appear.
